mlp_io_sequencer: RTL and testbench



---
 rtl/mlp_seq_pkg.sv | 21 ++
 rtl/mlp_settle_timer.sv | 36 +++
 rtl/mlp_io_sequencer.sv | 156 +++++++++++++++
 tb/tb_mlp_io_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_seq_pkg.sv
// Shared types and default constants for the printed-MLP I/O sequencer.
// Optional double-sample check is enabled with MLP_SEQ_DOUBLE_SAMPLE_EN.
package mlp_seq_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int NUM_A_DEF    = 8;
  localparam int WIDTH_A_DEF  = 4;
  localparam int OUTWIDTH_DEF = 2;
  localparam int SETTLE_CNT_W = 8;

  // Index width that stays legal for a single-feature configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_settle_timer.sv
// Loadable down-counter timing the MLP settle window.
// The `one` output exists only when MLP_SEQ_DOUBLE_SAMPLE_EN is defined.
module mlp_settle_timer
  import mlp_seq_pkg::*;
#(
  parameter int W = SETTLE_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
  output logic         one,
`endif
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);
`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
  assign one  = (count_reg == W'(1));
`endif

endmodule

// File: rtl/mlp_io_sequencer.sv
// Feeds features into the combinational printed MLP, waits out its settle time,
// and captures the class result. MLP_SEQ_DOUBLE_SAMPLE_EN adds a late-settle check.
module mlp_io_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_A         = NUM_A_DEF,
  parameter int WIDTH_A       = WIDTH_A_DEF,
  parameter int OUTWIDTH      = OUTWIDTH_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_feat,
  output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUTWIDTH-1:0]        m_class,
  output logic                       m_mismatch,
  output logic                       busy
);

  localparam int                      IDX_W       = idx_width(NUM_A);
  localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(NUM_A - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [IDX_W-1:0]     idx_reg;
  logic [WIDTH_A-1:0]   slot_reg [NUM_A];
  logic [OUTWIDTH-1:0]  class_reg;

  logic accept;
  logic last_accept;
  logic capture;
  logic result_done;
  logic timer_dec;
  logic timer_zero;

  assign accept      = s_valid && s_ready;
  assign last_accept = accept && (idx_reg == LAST_IDX);
  assign capture     = (state_reg == SETTLE) && timer_zero;
  assign result_done = (state_reg == RESULT) && m_ready;
  assign timer_dec   = (state_reg == SETTLE) && !timer_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (last_accept) state_next = SETTLE;
      SETTLE:  if (timer_zero)  state_next = RESULT;
      RESULT:  if (result_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Handshake outputs decode straight from the registered state.
  always_comb begin
    s_ready = (state_reg == LOAD) && !rst;
    m_valid = (state_reg == RESULT);
    busy    = (state_reg != LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (accept) begin
      idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // Slots are only written in LOAD, so the MLP input is frozen while it settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_A; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (accept) begin
      slot_reg[idx_reg] <= s_feat;
    end
  end

  for (genvar gi = 0; gi < NUM_A; gi++) begin : g_pack
    assign mlp_inp[gi*WIDTH_A +: WIDTH_A] = slot_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_reg <= '0;
    end else if (capture) begin
      class_reg <= mlp_out;
    end
  end

  assign m_class = class_reg;

`ifdef MLP_SEQ_DOUBLE_SAMPLE_EN
  logic                timer_one;
  logic [OUTWIDTH-1:0] shadow_reg;
  logic                mismatch_reg;

  mlp_settle_timer #(
    .W(SETTLE_CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (last_accept),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .one      (timer_one),
    .zero     (timer_zero)
  );

  // A disagreement between the last two settle cycles flags a late or glitching path.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg   <= '0;
      mismatch_reg <= 1'b0;
    end else begin
      if ((state_reg == SETTLE) && timer_one) begin
        shadow_reg <= mlp_out;
      end
      if (capture) begin
        mismatch_reg <= (shadow_reg != mlp_out);
      end else if (result_done) begin
        mismatch_reg <= 1'b0;
      end
    end
  end

  assign m_mismatch = mismatch_reg;
`else
  mlp_settle_timer #(
    .W(SETTLE_CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (last_accept),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign m_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_io_sequencer.sv
// Randomized scoreboard bench for mlp_io_sequencer with a behavioural stand-in for the MLP.
module tb_mlp_io_sequencer;
  localparam int N  = 8;
  localparam int W  = 4;
  localparam int OW = 2;
  localparam int S  = 4;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [W-1:0]      s_feat;
  logic [N*W-1:0]    mlp_inp;
  logic [OW-1:0]     mlp_out;
  logic              m_valid;
  logic              m_ready;
  logic [OW-1:0]     m_class;
  logic              m_mismatch;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int ready_pct = 100;
  int stall_left = 0;
  logic [OW-1:0] exp_q[$];

  mlp_io_sequencer #(
    .NUM_A(N), .WIDTH_A(W), .OUTWIDTH(OW), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_feat(s_feat),
    .mlp_inp(mlp_inp), .mlp_out(mlp_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_mismatch(m_mismatch), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Stand-in classifier: position-weighted feature sum, so slot order matters.
  function automatic logic [OW-1:0] mlp_fn(input logic [N*W-1:0] v);
    int acc = 0;
    for (int i = 0; i < N; i++) acc += (i + 1) * int'(v[i*W +: W]);
    return OW'(acc % 4);
  endfunction

  always_comb mlp_out = mlp_fn(mlp_inp);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        m_ready = 0;
        if (m_valid) stall_left--;
      end else begin
        m_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
    end
  end

  // Monitor: reference model of the protocol, sampled on the falling edge.
  initial begin
    int cyc = 0;
    int m_acc = 0;
    int m_e = 0;
    bit m_busy = 0;
    bit prev_rst = 1;
    logic [W-1:0] m_feat [N];
    logic [N*W-1:0] m_inp;
    logic [OW-1:0] exp_cls;
    for (int i = 0; i < N; i++) m_feat[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      m_inp = '0;
      for (int i = 0; i < N; i++) m_inp = m_inp | ((N*W)'(m_feat[i]) << (i * W));
      if (prev_rst) begin
        check("rst_inp", mlp_inp, 0);
        check("rst_valid", m_valid, 0);
        check("rst_class", m_class, 0);
        check("rst_mismatch", m_mismatch, 0);
        check("rst_busy", busy, 0);
      end else begin
        check("busy", busy, m_busy);
        check("m_valid", m_valid, m_busy && (cyc >= m_e + S + 1));
        check("mlp_inp", mlp_inp, m_inp);
      end
      check("s_ready", s_ready, !rst && !m_busy);
      if (!rst && m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result_unexpected actual=valid required=idle t=%0t", $time);
        end else begin
          check("m_class_hold", m_class, exp_q[0]);
        end
      end
      if (rst) begin
        m_busy = 0;
        m_acc = 0;
        for (int i = 0; i < N; i++) m_feat[i] = '0;
      end else if (s_valid && s_ready) begin
        m_feat[m_acc] = s_feat;
        if (m_acc == N - 1) begin
          m_acc = 0;
          m_busy = 1;
          m_e = cyc;
        end else begin
          m_acc++;
        end
      end else if (m_valid && m_ready) begin
        if (exp_q.size() > 0) begin
          exp_cls = exp_q.pop_front();
          check("m_class", m_class, exp_cls);
          check("m_mismatch", m_mismatch, 0);
          $display("result class=%0d inp=%h t=%0t", m_class, mlp_inp, $time);
        end
        m_busy = 0;
      end
      prev_rst = rst;
    end
  end

  task automatic send_feat(input logic [W-1:0] f, input bit gap);
    int n = 0;
    if (gap) begin
      s_valid = 0;
      @(posedge clk); #1;
    end
    s_valid = 1;
    s_feat = f;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=stalled required=s_ready t=%0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_sample(input logic [N*W-1:0] v, input bit gap);
    for (int i = 0; i < N; i++) send_feat(v[i*W +: W], gap);
    exp_q.push_back(mlp_fn(v));
  endtask

  task automatic pulse_rst();
    s_valid = 0;
    exp_q.delete();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int n;
    rst = 1;
    s_valid = 0;
    s_feat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    send_sample(32'h4921_7F03, 0);
    @(negedge clk);
    check("pack_4921_7f03", mlp_inp, 64'h4921_7F03);

    send_sample($urandom(), 1);
    stall_left = 10;
    send_sample($urandom(), 0);

    for (int i = 0; i < 5; i++) send_feat(W'($urandom_range(0, 15)), 0);
    pulse_rst();
    send_sample($urandom(), 0);
    s_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_rst();
    send_sample($urandom(), 0);

    ready_pct = 50;
    repeat (20) send_sample($urandom(), 1'($urandom_range(0, 1)));
    ready_pct = 100;
    repeat (4) send_sample($urandom(), 0);
    s_valid = 0;

    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
